// File: rtl/key_expand_ctrl.sv
// AES-128 key schedule feeder: RotWord, byte-serial SubWord through a shared S-box port, Rcon XOR, round sequencing.
// Build option ROUND_KEY_STORE_EN adds an (NR+1)-entry readable round key store.
module key_expand_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    input  logic [KW-1:0] round_key,
    input  logic          key_flag,
    output logic [7:0]    sbox_addr,
    input  logic [7:0]    sbox_data,
    output logic [31:0]   s_boxed_row,
    output logic          row_valid,
    output logic [3:0]    round_num,
    output logic          busy,
    output logic          done,
    input  logic [3:0]    rk_rd_addr,
    output logic [KW-1:0] rk_rd_data
);

    typedef enum logic [3:0] {
        IDLE, LOAD, SUB0, SUB1, SUB2, SUB3, RCON, HOLD, DONE
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] cur_key_q, cur_key_d;
    logic [31:0]   rot_q, rot_d;
    logic [31:0]   sub_q, sub_d;
    logic [31:0]   s_boxed_q, s_boxed_d;
    logic          row_valid_q, row_valid_d;
    logic          busy_q, busy_d;
    logic [3:0]    round_q, round_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          more_rounds;

    // Last column of a round key is key[31:0] with row 0 in the top byte;
    // result is {row3,row2,row1,row0} where rot row r = column row (r+1)%4.
    function automatic logic [31:0] rot_word(input logic [31:0] col);
        return {col[31:24], col[7:0], col[15:8], col[23:16]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    assign more_rounds = (round_q < 4'(NR));

    always_comb begin
        state_d     = state_q;
        cur_key_d   = cur_key_q;
        rot_d       = rot_q;
        sub_d       = sub_q;
        s_boxed_d   = s_boxed_q;
        row_valid_d = row_valid_q;
        busy_d      = busy_q;
        round_d     = round_q;
        rcon_d      = rcon_q;
        sbox_addr   = '0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_key_d = key_in;
                    round_d   = 4'd1;
                    rcon_d    = 8'h01;
                    busy_d    = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                rot_d   = rot_word(cur_key_q[31:0]);
                state_d = SUB0;
            end
            SUB0, SUB1, SUB2, SUB3: begin
                // Row 0 leaves the bottom of rot_q first; results enter sub_q from the top.
                sbox_addr = rot_q[7:0];
                sub_d     = {sbox_data, sub_q[31:8]};
                rot_d     = {8'h00, rot_q[31:8]};
                case (state_q)
                    SUB0:    state_d = SUB1;
                    SUB1:    state_d = SUB2;
                    SUB2:    state_d = SUB3;
                    default: state_d = RCON;
                endcase
            end
            RCON: begin
                s_boxed_d   = sub_q ^ {24'h000000, rcon_q};
                row_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (key_flag) begin
                    cur_key_d   = round_key;
                    row_valid_d = 1'b0;
                    if (more_rounds) begin
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                        // Skip LOAD: rotate the incoming key directly to hit 5-cycle turnaround.
                        rot_d   = rot_word(round_key[31:0]);
                        state_d = SUB0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                round_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_key_q   <= '0;
            rot_q       <= '0;
            sub_q       <= '0;
            s_boxed_q   <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            round_q     <= '0;
            rcon_q      <= 8'h01;
        end else begin
            state_q     <= state_d;
            cur_key_q   <= cur_key_d;
            rot_q       <= rot_d;
            sub_q       <= sub_d;
            s_boxed_q   <= s_boxed_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
        end
    end

    assign s_boxed_row = s_boxed_q;
    assign row_valid   = row_valid_q;
    assign round_num   = round_q;
    assign busy        = busy_q;

    logic unused_key_hi;
    assign unused_key_hi = ^cur_key_q[KW-1:32];

`ifdef ROUND_KEY_STORE_EN
    logic [KW-1:0] store_q [0:NR];
    logic          store_we;
    logic [3:0]    store_idx;
    logic [KW-1:0] store_wdata;

    always_comb begin
        store_we    = 1'b0;
        store_idx   = '0;
        store_wdata = '0;
        if (state_q == IDLE && start) begin
            store_we    = 1'b1;
            store_wdata = key_in;
        end else if (state_q == HOLD && key_flag) begin
            store_we    = 1'b1;
            store_idx   = round_q;
            store_wdata = round_key;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                store_q[i] <= '0;
            end
        end else if (store_we) begin
            store_q[store_idx] <= store_wdata;
        end
    end

    assign rk_rd_data = (rk_rd_addr <= 4'(NR)) ? store_q[rk_rd_addr] : '0;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rk_rd_addr;
    assign rk_rd_data     = '0;
`endif

endmodule
